// File: rtl/nic_out_vc_tracker.sv
// nic_out_vc_tracker
// Output-side VC bookkeeping between the NiC slave interface and the router
// injection link. Registers the outgoing flit, tracks the owning
// fifo_out_buffer of each downstream VC, and counts outstanding flits per VC
// against the router buffer depth. Router credits are forwarded to the owner
// while a VC is allocated and absorbed while it drains after release.
//
// Optional feature: define NIC_VC_ERR_CHECK_EN to add a sticky err_o[3:0]
// protocol-violation output (cleared only by rst).

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module nic_out_vc_tracker #(
    parameter int N_TOT_OF_VC            = 6,
    parameter int N_BITS_FIFO_OUT_BUFFER = 3,
    parameter int N_BITS_CREDIT          = 4,
    parameter int BUFFER_DEPTH           = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [N_TOT_OF_VC-1:0]                        g_fifo_pointer_i,
    input  logic [N_TOT_OF_VC*N_BITS_FIFO_OUT_BUFFER-1:0] g_fifo_out_buffer_id_i,
    input  logic [N_TOT_OF_VC-1:0]                        release_pointer_i,
    input  logic [`FLIT_WIDTH-1:0]                        in_flit_i,
    input  logic                                          in_valid_i,
    input  logic [N_TOT_OF_VC-1:0]                        in_vc_i,
    input  logic [N_TOT_OF_VC-1:0]                        credit_i,
    output logic [`FLIT_WIDTH-1:0]                        out_link_o,
    output logic                                          is_valid_o,
    output logic [N_TOT_OF_VC-1:0]                        credit_signal_o,
    output logic [N_TOT_OF_VC*N_BITS_FIFO_OUT_BUFFER-1:0] fifo_pointed_o,
    output logic [N_TOT_OF_VC-1:0]                        vc_free_o
`ifdef NIC_VC_ERR_CHECK_EN
    ,
    output logic [3:0]                                    err_o
`endif
);

    localparam int ID_W = N_TOT_OF_VC * N_BITS_FIFO_OUT_BUFFER;
    localparam logic [N_BITS_CREDIT-1:0] DEPTH_C = N_BITS_CREDIT'(BUFFER_DEPTH);
    localparam logic [N_BITS_CREDIT-1:0] ONE_C   = N_BITS_CREDIT'(1);
    localparam logic [N_BITS_CREDIT-1:0] ZERO_C  = N_BITS_CREDIT'(0);

    typedef enum logic [1:0] {
        VC_IDLE      = 2'd0,
        VC_ALLOCATED = 2'd1,
        VC_RELEASING = 2'd2
    } vc_state_t;

    vc_state_t                state_q [N_TOT_OF_VC];
    vc_state_t                state_d [N_TOT_OF_VC];
    logic [N_BITS_CREDIT-1:0] cnt_q   [N_TOT_OF_VC];
    logic [N_BITS_CREDIT-1:0] cnt_d   [N_TOT_OF_VC];
    logic [ID_W-1:0]          owner_q;
    logic [ID_W-1:0]          owner_d;
    logic [N_TOT_OF_VC-1:0]   credit_q;
    logic [N_TOT_OF_VC-1:0]   credit_d;
    logic [`FLIT_WIDTH-1:0]   flit_q;
    logic [`FLIT_WIDTH-1:0]   flit_d;
    logic                     valid_q;

    logic [N_TOT_OF_VC-1:0]   free_s;
    logic [N_TOT_OF_VC-1:0]   inc_s;
    logic [N_TOT_OF_VC-1:0]   dec_s;

    // Idle flags, flit arrivals and effective (non-ignored) credits per VC
    always_comb begin
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            free_s[v] = (state_q[v] == VC_IDLE);
        end
        inc_s = {N_TOT_OF_VC{in_valid_i}} & in_vc_i;
        dec_s = credit_i & ~free_s;
    end

    // Saturating outstanding-flit counter per VC; flit and credit together cancel
    always_comb begin
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            cnt_d[v] = cnt_q[v];
            if (inc_s[v] && !dec_s[v]) begin
                if (cnt_q[v] != DEPTH_C) begin
                    cnt_d[v] = cnt_q[v] + ONE_C;
                end else begin
                    cnt_d[v] = cnt_q[v];
                end
            end else if (dec_s[v] && !inc_s[v]) begin
                if (cnt_q[v] != ZERO_C) begin
                    cnt_d[v] = cnt_q[v] - ONE_C;
                end else begin
                    cnt_d[v] = cnt_q[v];
                end
            end else begin
                cnt_d[v] = cnt_q[v];
            end
        end
    end

    // Per-VC ownership FSM: allocate on grant, forward credits, drain on release
    always_comb begin
        owner_d  = owner_q;
        credit_d = {N_TOT_OF_VC{1'b0}};
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            state_d[v] = state_q[v];
            case (state_q[v])
                VC_IDLE: begin
                    if (g_fifo_pointer_i[v]) begin
                        state_d[v] = VC_ALLOCATED;
                        owner_d[v*N_BITS_FIFO_OUT_BUFFER +: N_BITS_FIFO_OUT_BUFFER] =
                            g_fifo_out_buffer_id_i[v*N_BITS_FIFO_OUT_BUFFER +: N_BITS_FIFO_OUT_BUFFER];
                    end else begin
                        state_d[v] = VC_IDLE;
                    end
                end
                VC_ALLOCATED: begin
                    if (release_pointer_i[v]) begin
                        // a credit landing in the release cycle is absorbed here
                        if (cnt_d[v] != ZERO_C) begin
                            state_d[v] = VC_RELEASING;
                        end else begin
                            state_d[v] = VC_IDLE;
                        end
                    end else if (credit_i[v]) begin
                        credit_d[v] = 1'b1;
                    end else begin
                        state_d[v] = VC_ALLOCATED;
                    end
                end
                VC_RELEASING: begin
                    if (cnt_d[v] == ZERO_C) begin
                        state_d[v] = VC_IDLE;
                    end else begin
                        state_d[v] = VC_RELEASING;
                    end
                end
                default: begin
                    state_d[v] = VC_IDLE;
                end
            endcase
        end
    end

    // Flit register holds its last value while the input is not valid
    always_comb begin
        if (in_valid_i) begin
            flit_d = in_flit_i;
        end else begin
            flit_d = flit_q;
        end
    end

    // State, counter, owner, credit and link registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < N_TOT_OF_VC; v++) begin
                state_q[v] <= VC_IDLE;
                cnt_q[v]   <= ZERO_C;
            end
            owner_q  <= {ID_W{1'b0}};
            credit_q <= {N_TOT_OF_VC{1'b0}};
            flit_q   <= {`FLIT_WIDTH{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            for (int v = 0; v < N_TOT_OF_VC; v++) begin
                state_q[v] <= state_d[v];
                cnt_q[v]   <= cnt_d[v];
            end
            owner_q  <= owner_d;
            credit_q <= credit_d;
            flit_q   <= flit_d;
            valid_q  <= in_valid_i;
        end
    end

    assign out_link_o      = flit_q;
    assign is_valid_o      = valid_q;
    assign credit_signal_o = credit_q;
    assign fifo_pointed_o  = owner_q;
    assign vc_free_o       = free_s;

`ifdef NIC_VC_ERR_CHECK_EN
    logic [3:0]             err_q;
    logic [3:0]             err_d;
    logic [N_TOT_OF_VC-1:0] cnt_zero_s;
    logic [N_TOT_OF_VC-1:0] cnt_full_s;

    // Sticky protocol-violation flags
    always_comb begin
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            cnt_zero_s[v] = (cnt_q[v] == ZERO_C);
            cnt_full_s[v] = (cnt_q[v] == DEPTH_C);
        end
        err_d    = err_q;
        err_d[0] = err_q[0] | (|(g_fifo_pointer_i & ~free_s));
        err_d[1] = err_q[1] | (|(credit_i & (free_s | cnt_zero_s)));
        err_d[2] = err_q[2] | (|(inc_s & free_s));
        err_d[3] = err_q[3] | (|(inc_s & cnt_full_s));
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 4'b0000;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_nic_out_vc_tracker.sv
// Directed testbench for nic_out_vc_tracker.
// Inputs change just after the falling edge; outputs are checked at the
// following falling edge, one rising edge later.

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module tb_nic_out_vc_tracker;

    localparam int NVC = 6;
    localparam int IDB = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NVC-1:0]         g_ptr;
    logic [NVC*IDB-1:0]     g_id;
    logic [NVC-1:0]         rel;
    logic [`FLIT_WIDTH-1:0] flit;
    logic                   valid;
    logic [NVC-1:0]         vc;
    logic [NVC-1:0]         credit;
    logic [`FLIT_WIDTH-1:0] out_link;
    logic                   is_valid;
    logic [NVC-1:0]         credit_sig;
    logic [NVC*IDB-1:0]     fifo_pointed;
    logic [NVC-1:0]         vc_free;
`ifdef NIC_VC_ERR_CHECK_EN
    logic [3:0]             err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    nic_out_vc_tracker dut (
        .clk                    (clk),
        .rst                    (rst),
        .g_fifo_pointer_i       (g_ptr),
        .g_fifo_out_buffer_id_i (g_id),
        .release_pointer_i      (rel),
        .in_flit_i              (flit),
        .in_valid_i             (valid),
        .in_vc_i                (vc),
        .credit_i               (credit),
        .out_link_o             (out_link),
        .is_valid_o             (is_valid),
        .credit_signal_o        (credit_sig),
        .fifo_pointed_o         (fifo_pointed),
        .vc_free_o              (vc_free)
`ifdef NIC_VC_ERR_CHECK_EN
        ,
        .err_o                  (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        g_ptr  = '0;
        g_id   = '0;
        rel    = '0;
        flit   = '0;
        valid  = 1'b0;
        vc     = '0;
        credit = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();

        // reset / idle state
        chk("rst_vc_free", 64'(vc_free), 64'h3F);
        chk("rst_is_valid", 64'(is_valid), 64'h0);
        chk("rst_credit", 64'(credit_sig), 64'h0);
        chk("rst_fifo_pointed", 64'(fifo_pointed), 64'h0);
        chk("rst_out_link", 64'(out_link), 64'h0);

        // grant VC2 to owner 5
        g_ptr = 6'b000100;
        g_id[8:6] = 3'd5;
        tick();
        idle_inputs();
        chk("grant2_owner", 64'(fifo_pointed[8:6]), 64'h5);
        chk("grant2_vc_free", 64'(vc_free), 64'h3B);

        // three flits on VC2
        for (int k = 0; k < 3; k++) begin
            valid = 1'b1;
            vc    = 6'b000100;
            flit  = 32'hA000_0000 + 32'(k);
            tick();
            chk("flit2_link", 64'(out_link), 64'hA000_0000 + 64'(k));
            chk("flit2_valid", 64'(is_valid), 64'h1);
        end
        idle_inputs();
        tick();
        chk("hold_valid", 64'(is_valid), 64'h0);
        chk("hold_link", 64'(out_link), 64'hA000_0002);
        chk("cnt2_after_flits", 64'(dut.cnt_q[2]), 64'h3);

        // three credits on VC2, each forwarded one cycle later as a pulse
        for (int k = 0; k < 3; k++) begin
            credit = 6'b000100;
            tick();
            credit = '0;
            chk("credit2_pulse", 64'(credit_sig), 64'h04);
            tick();
            chk("credit2_clear", 64'(credit_sig), 64'h00);
        end
        chk("cnt2_after_credits", 64'(dut.cnt_q[2]), 64'h0);

        // one flit, then tail flit together with release
        valid = 1'b1; vc = 6'b000100; flit = 32'hB000_0001;
        tick();
        flit = 32'hB000_0002; rel = 6'b000100;
        tick();
        idle_inputs();
        chk("tail_cnt", 64'(dut.cnt_q[2]), 64'h2);
        chk("tail_not_free", 64'(vc_free[2]), 64'h0);
        credit = 6'b000100;
        tick();
        credit = '0;
        chk("rel_credit1_absorbed", 64'(credit_sig), 64'h0);
        chk("rel_credit1_busy", 64'(vc_free[2]), 64'h0);
        credit = 6'b000100;
        tick();
        credit = '0;
        chk("rel_credit2_absorbed", 64'(credit_sig), 64'h0);
        chk("rel_credit2_free", 64'(vc_free[2]), 64'h1);

        // release with zero count returns to IDLE at once
        g_ptr = 6'b001000; g_id[11:9] = 3'd6;
        tick();
        idle_inputs();
        chk("grant3_owner", 64'(fifo_pointed[11:9]), 64'h6);
        chk("grant3_busy", 64'(vc_free[3]), 64'h0);
        rel = 6'b001000;
        tick();
        idle_inputs();
        chk("rel3_free", 64'(vc_free[3]), 64'h1);

        // VC0: count 2, then simultaneous flit and credit
        g_ptr = 6'b000001; g_id[2:0] = 3'd1;
        tick();
        idle_inputs();
        valid = 1'b1; vc = 6'b000001; flit = 32'hC000_0000;
        tick();
        tick();
        chk("cnt0_two", 64'(dut.cnt_q[0]), 64'h2);
        credit = 6'b000001; flit = 32'hC000_0003;
        tick();
        idle_inputs();
        chk("cnt0_net_zero", 64'(dut.cnt_q[0]), 64'h2);
        chk("cnt0_credit_fwd", 64'(credit_sig), 64'h01);

        // grant on an allocated VC is ignored; credit on idle VC is ignored
        g_ptr = 6'b000001; g_id[2:0] = 3'd7; credit = 6'b010000;
        tick();
        idle_inputs();
        chk("regrant_ignored", 64'(fifo_pointed[2:0]), 64'h1);
        chk("idle_credit_ignored", 64'(credit_sig), 64'h0);

        // reset in the middle of operation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_free", 64'(vc_free), 64'h3F);
        chk("midrst_owner", 64'(fifo_pointed), 64'h0);
        chk("midrst_cnt0", 64'(dut.cnt_q[0]), 64'h0);
        chk("midrst_link", 64'(out_link), 64'h0);
`ifdef NIC_VC_ERR_CHECK_EN
        chk("midrst_err", 64'(err), 64'h0);
`endif

        // five flits on VC1 saturate the counter at BUFFER_DEPTH
        g_ptr = 6'b000010; g_id[5:3] = 3'd2;
        tick();
        idle_inputs();
        valid = 1'b1; vc = 6'b000010; flit = 32'hD000_0000;
        repeat (4) tick();
        chk("cnt1_full", 64'(dut.cnt_q[1]), 64'h4);
`ifdef NIC_VC_ERR_CHECK_EN
        chk("err_before_overflow", 64'(err), 64'h0);
`endif
        tick();
        idle_inputs();
        chk("cnt1_saturated", 64'(dut.cnt_q[1]), 64'h4);
`ifdef NIC_VC_ERR_CHECK_EN
        chk("err_overflow", 64'(err), 64'h8);
        repeat (2) tick();
        chk("err_sticky", 64'(err), 64'h8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_cleared", 64'(err), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
